// File: rtl/mem_access_stage.sv
// MEM stage: drives the data bus with a req/ready handshake, stalls the
// upstream pipeline while an access is outstanding, and fills MEM/WB.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemtoReg_mem,
  input  logic        RegWrite_mem,
  input  logic        MemWrite_mem,
  input  logic [31:0] ALUResult_mem,
  input  logic [31:0] MemWriteData_mem,
  input  logic [4:0]  rdAddr_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic        RegWrite_wb,
  output logic [4:0]  rdAddr_wb,
  output logic [31:0] WBData_wb,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0]   rdata_q, rdata_nx;
  logic          req_nx, we_nx, err_nx;
  logic [31:0]   addr_nx, wdata_nx;
  logic          rw_nx;
  logic [4:0]    rd_nx;
  logic [31:0]   wb_nx;
  logic          access;
  logic          is_load;

  assign access  = MemtoReg_mem | MemWrite_mem;
  assign is_load = MemtoReg_mem & ~MemWrite_mem;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    rdata_nx  = rdata_q;
    req_nx    = dmem_req;
    we_nx     = dmem_we;
    addr_nx   = dmem_addr;
    wdata_nx  = dmem_wdata;
    err_nx    = bus_err;
    rw_nx     = RegWrite_wb;
    rd_nx     = rdAddr_wb;
    wb_nx     = WBData_wb;
    stall_mem = 1'b0;
    unique case (state)
      IDLE: begin
        if (access) begin
          stall_mem = 1'b1;
          rw_nx     = 1'b0;
          addr_nx   = ALUResult_mem;
          wdata_nx  = MemWriteData_mem;
          we_nx     = MemWrite_mem;
          req_nx    = 1'b1;
          cnt_nx    = '0;
          state_nx  = REQ;
        end else begin
          rw_nx = RegWrite_mem;
          rd_nx = rdAddr_mem;
          wb_nx = ALUResult_mem;
        end
      end
      REQ: begin
        stall_mem = 1'b1;
        rw_nx     = 1'b0;
        if (dmem_ready) begin
          rdata_nx = dmem_rdata;
          req_nx   = 1'b0;
          state_nx = DONE;
        end else if (cnt == LAST) begin
          rdata_nx = '0;
          req_nx   = 1'b0;
          err_nx   = 1'b1;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      DONE: begin
        rw_nx    = RegWrite_mem;
        rd_nx    = rdAddr_mem;
        wb_nx    = is_load ? rdata_q : ALUResult_mem;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Upstream must never freeze while reset is asserted.
    if (!rst_n) stall_mem = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rdata_q     <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      bus_err     <= 1'b0;
      RegWrite_wb <= 1'b0;
      rdAddr_wb   <= '0;
      WBData_wb   <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      rdata_q     <= rdata_nx;
      dmem_req    <= req_nx;
      dmem_we     <= we_nx;
      dmem_addr   <= addr_nx;
      dmem_wdata  <= wdata_nx;
      bus_err     <= err_nx;
      RegWrite_wb <= rw_nx;
      rdAddr_wb   <= rd_nx;
      WBData_wb   <= wb_nx;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: random pipeline traffic against
// a memory responder and a transaction-level reference model.
module tb_mem_access_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemtoReg_mem = 1'b0;
  logic        RegWrite_mem = 1'b0;
  logic        MemWrite_mem = 1'b0;
  logic [31:0] ALUResult_mem = '0;
  logic [31:0] MemWriteData_mem = '0;
  logic [4:0]  rdAddr_mem = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        stall_mem, RegWrite_wb, bus_err;
  logic [4:0]  rdAddr_wb;
  logic [31:0] WBData_wb;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemtoReg_mem(MemtoReg_mem), .RegWrite_mem(RegWrite_mem),
    .MemWrite_mem(MemWrite_mem), .ALUResult_mem(ALUResult_mem),
    .MemWriteData_mem(MemWriteData_mem), .rdAddr_mem(rdAddr_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .stall_mem(stall_mem),
    .RegWrite_wb(RegWrite_wb), .rdAddr_wb(rdAddr_wb),
    .WBData_wb(WBData_wb), .bus_err(bus_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } bus_t;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } wb_t;

  bus_t bus_q[$];
  wb_t  wb_q[$];
  int   lat_q[$];

  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  bit mon_en = 0;
  bit inst_valid = 0;
  bit exp_err = 0;

  // Memory responder: latency per access is chosen by the stimulus.
  bit r_act = 0;
  int r_cnt, r_lat;
  always @(negedge clk) begin
    if (dmem_req) begin
      if (!r_act) begin
        r_act = 1;
        r_cnt = 0;
        r_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1000;
      end
      r_cnt++;
      if (r_cnt == r_lat) begin
        dmem_ready = 1'b1;
        if (dmem_we) begin
          mem[dmem_addr] = dmem_wdata;
          dmem_rdata = $urandom;
        end else begin
          dmem_rdata = mem_rd(dmem_addr);
        end
      end else begin
        dmem_ready = 1'b0;
        dmem_rdata = $urandom;
      end
    end else begin
      r_act = 0;
      dmem_ready = ($urandom_range(0, 3) == 0);
      dmem_rdata = $urandom;
    end
  end

  // Bus monitor
  bus_t cur;
  int   b_cyc = 0;
  bit   b_prev = 0;
  bit   b_stable = 1;
  always @(negedge clk) begin
    if (mon_en) begin
      if (dmem_req && !b_prev) begin
        if (bus_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bus_spurious: got req addr %h expected none",
                   dmem_addr);
          cur.we = dmem_we;
          cur.addr = dmem_addr;
          cur.wdata = dmem_wdata;
          cur.cyc = -1;
        end else begin
          cur = bus_q.pop_front();
          chk("bus_we", 32'(dmem_we), 32'(cur.we));
          chk("bus_addr", dmem_addr, cur.addr);
          chk("bus_wdata", dmem_wdata, cur.wdata);
        end
        b_cyc = 0;
        b_stable = 1;
      end
      if (dmem_req) begin
        b_cyc++;
        if (dmem_we !== cur.we || dmem_addr !== cur.addr ||
            dmem_wdata !== cur.wdata)
          b_stable = 0;
      end
      if (!dmem_req && b_prev) begin
        chk("bus_req_cycles", 32'(b_cyc), 32'(cur.cyc));
        chk("bus_stable", 32'(b_stable), 32'd1);
      end
      b_prev = dmem_req;
    end else begin
      b_prev = 0;
    end
  end

  // Write-back monitor: an instruction leaves MEM on an edge without stall.
  wb_t e;
  bit  pend = 0;
  always @(negedge clk) begin
    if (pend) begin
      if (wb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_spurious: got rd %0d expected none", rdAddr_wb);
      end else begin
        e = wb_q.pop_front();
        chk("wb_regwrite", 32'(RegWrite_wb), 32'(e.rw));
        chk("wb_rd", 32'(rdAddr_wb), 32'(e.rd));
        chk("wb_data", WBData_wb, e.data);
        chk("bus_err", 32'(bus_err), 32'(e.err));
      end
    end
    pend = mon_en && rst_n && inst_valid && !stall_mem;
  end

  task automatic issue(input logic ml, input logic rw, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input int lat);
    bit   acc, to, done;
    int   stl, exp_stl;
    wb_t  w;
    bus_t b;
    acc = ml | mw;
    to = acc && (lat > T);
    MemtoReg_mem = ml;
    RegWrite_mem = rw;
    MemWrite_mem = mw;
    ALUResult_mem = alu;
    MemWriteData_mem = wd;
    rdAddr_mem = rd;
    inst_valid = 1;
    w.rw = rw;
    w.rd = rd;
    w.data = alu;
    exp_stl = 0;
    if (acc) begin
      b.we = mw;
      b.addr = alu;
      b.wdata = wd;
      b.cyc = to ? T : lat;
      exp_stl = b.cyc + 1;
      lat_q.push_back(lat);
      bus_q.push_back(b);
      if (mw) begin
        if (!to) ref_mem[alu] = wd;
      end else begin
        w.data = to ? 32'h0 : ref_rd(alu);
      end
    end
    exp_err = exp_err | to;
    w.err = exp_err;
    wb_q.push_back(w);
    stl = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!stall_mem) done = 1;
      else stl++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL stall_bound: got stall > 40 cycles expected %0d",
               exp_stl);
    end else begin
      chk("stall_cycles", 32'(stl), 32'(exp_stl));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  int kind, lat;
  logic [31:0] a;
  bit seen;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_stall", 32'(stall_mem), 32'd0);
    chk("rst_rw_wb", 32'(RegWrite_wb), 32'd0);
    chk("rst_rd_wb", 32'(rdAddr_wb), 32'd0);
    chk("rst_wbdata", WBData_wb, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1;

    mem[32'h100] = 32'hCAFEF00D;
    ref_mem[32'h100] = 32'hCAFEF00D;
    issue(1'b0, 1'b1, 1'b0, 32'h1234, 32'h0, 5'd5, 0);
    issue(1'b1, 1'b1, 1'b0, 32'h100, $urandom, 5'd8, 1);
    issue(1'b0, 1'b0, 1'b1, 32'h204, 32'hA5A5A5A5, 5'd3, 4);
    issue(1'b1, 1'b1, 1'b0, 32'h208, $urandom, 5'd9, 100);
    issue(1'b0, 1'b1, 1'b0, 32'h55AA, 32'h0, 5'd4, 0);
    issue(1'b1, 1'b1, 1'b0, 32'h204, $urandom, 5'd10, 2);
    issue(1'b1, 1'b1, 1'b0, 32'h100, $urandom, 5'd11, 1);
    issue(1'b1, 1'b1, 1'b1, 32'h10C, 32'h13572468, 5'd12, 3);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      lat = ($urandom_range(0, 15) == 0) ? 50 : $urandom_range(1, T);
      a = 32'h100 + {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      if (kind <= 3)
        issue(1'b0, 1'($urandom), 1'b0, $urandom, $urandom,
              5'($urandom), 0);
      else if (kind <= 6)
        issue(1'b1, 1'($urandom), 1'b0, a, $urandom, 5'($urandom), lat);
      else if (kind <= 8)
        issue(1'b0, 1'($urandom), 1'b1, a, $urandom, 5'($urandom), lat);
      else
        issue(1'b1, 1'($urandom), 1'b1, a, $urandom, 5'($urandom), lat);
    end

    inst_valid = 0;
    MemtoReg_mem = 1'b0;
    RegWrite_mem = 1'b0;
    MemWrite_mem = 1'b0;
    ALUResult_mem = '0;
    repeat (4) @(negedge clk);
    chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);

    mon_en = 0;
    @(posedge clk);
    #1;
    MemtoReg_mem = 1'b1;
    RegWrite_mem = 1'b1;
    rdAddr_mem = 5'd7;
    ALUResult_mem = 32'h300;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (dmem_req) seen = 1;
    end
    chk("mid_req_reached", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_stall_forced", 32'(stall_mem), 32'd0);
    @(negedge clk);
    chk("midrst_req", 32'(dmem_req), 32'd0);
    chk("midrst_stall", 32'(stall_mem), 32'd0);
    chk("midrst_bus_err", 32'(bus_err), 32'd0);
    chk("midrst_rw_wb", 32'(RegWrite_wb), 32'd0);
    chk("midrst_rd_wb", 32'(rdAddr_wb), 32'd0);
    chk("midrst_wbdata", WBData_wb, 32'd0);
    chk("midrst_addr", dmem_addr, 32'd0);
    MemtoReg_mem = 1'b0;
    RegWrite_mem = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_req", 32'(dmem_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM-stage controller of the 5-stage pipeline: the consumer of the EX/MEM pipeline register outputs. It drives a data-memory bus with a req/ready handshake, stalls the upstream pipeline while a load or store is outstanding, and registers the write-back result into the MEM/WB boundary. It sits between the EX/MEM register, the data memory, and the register-file write port.

## Interface
- TIMEOUT_CYCLES, 255: maximum REQ cycles before a bus-error abort (≥1)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous reset, active-low
- MemtoReg_mem  in  1  instruction is a load
- RegWrite_mem  in  1  instruction writes rd
- MemWrite_mem  in  1  instruction is a store
- ALUResult_mem  in  32  effective address / ALU result
- MemWriteData_mem  in  32  store data
- rdAddr_mem  in  5  destination register
- dmem_req  out  1  bus request, registered
- dmem_we  out  1  1 = write, registered
- dmem_addr  out  32  byte address, registered
- dmem_wdata  out  32  write data, registered
- dmem_ready  in  1  memory completes access at this edge
- dmem_rdata  in  32  read data, valid when dmem_ready=1
- stall_mem  out  1  combinational; hold PC, IF/ID, ID/EX, EX/MEM
- RegWrite_wb  out  1  MEM/WB write enable
- rdAddr_wb  out  5  MEM/WB destination
- WBData_wb  out  32  MEM/WB write data
- bus_err  out  1  sticky timeout flag

## Operation
- Access = MemtoReg_mem | MemWrite_mem. Both set: treated as store (dmem_we=1), WBData = ALUResult_mem.
- States: IDLE, REQ, DONE.
- IDLE: no access → no stall; MEM/WB loads {RegWrite_mem, rdAddr_mem, ALUResult_mem} every edge. Access → stall_mem=1, latch addr=ALUResult_mem, wdata=MemWriteData_mem, we=MemWrite_mem, set dmem_req=1, clear wait counter, go REQ.
- REQ: dmem_req held, addr/wdata/we stable, stall_mem=1. Edge with dmem_ready=1: capture dmem_rdata, dmem_req←0, go DONE. Else counter+1; if counter reaches TIMEOUT_CYCLES−1 with ready low: dmem_req←0, captured data←0, bus_err←1, go DONE.
- DONE: stall_mem=0; at edge MEM/WB loads RegWrite_mem, rdAddr_mem, WBData = MemtoReg_mem&~MemWrite_mem ? captured data : ALUResult_mem; go IDLE unconditionally (held inputs must not retrigger).
- Any edge with stall_mem=1: MEM/WB loads bubble (RegWrite_wb←0, rdAddr_wb, WBData_wb unchanged).
- dmem_ready ignored outside REQ.
- bus_err cleared only by reset.
- Counter width = ceil(log2(TIMEOUT_CYCLES))+1 bits; no wrap in use.

## Timing
- Reset (rst_n=0 at edge): state IDLE, dmem_req/dmem_we 0, dmem_addr/dmem_wdata 0, counter 0, RegWrite_wb 0, rdAddr_wb 0, WBData_wb 0, bus_err 0; stall_mem forced 0 while rst_n=0. Reset in REQ aborts access immediately (req drops next cycle).
- Non-memory instruction: 1 cycle in MEM, result in MEM/WB at following edge.
- Access seen cycle t: dmem_req high from t+1; ready at cycle t+k (k≥1) → DONE at t+k+1 → MEM/WB valid after edge ending t+k+1. Minimum 3 cycles in MEM, stall_mem high cycles t..t+k.
- Timeout: dmem_req high exactly TIMEOUT_CYCLES cycles, then DONE.
- Back-to-back accesses: second access seen in cycle after DONE; dmem_req low at least one cycle between accesses.

## Test plan
- Reset then ALU op (RegWrite=1, rd=5, ALU=0x1234): no stall; next edge RegWrite_wb=1, rdAddr_wb=5, WBData_wb=0x1234.
- Load addr 0x100, rd=8, ready first REQ cycle, rdata=0xCAFEF00D: dmem_req 1 cycle, we=0, stall 2 cycles, WBData_wb=0xCAFEF00D, rdAddr_wb=8, RegWrite_wb 0 during stall.
- Store addr 0x204, data 0xA5A5A5A5, ready after 4 REQ cycles: addr/wdata/we=1 stable all 4 cycles, stall 5 cycles, RegWrite_wb=0.
- TIMEOUT_CYCLES=4, load never ready: dmem_req exactly 4 cycles, bus_err=1 persists, WBData_wb=0, pipeline resumes.
- Back-to-back load/load: req drops between accesses, second rdata written correctly, no duplicate access.
- rst_n low mid-REQ: next cycle dmem_req=0, stall_mem=0, bus_err=0, all WB outputs 0.
